// File: rtl/text_overlay_pkg.sv
// Shared definitions for the scrolling text overlay.
//   COORD_W  : width of the VGA pixel coordinates (x, y)
//   cell_of  : pixel coordinate -> cell coordinate (right shift by the scale)
//   wrap_add : column add with a single conditional wrap, for a + b < 2*mod
package text_overlay_pkg;

    localparam int COORD_W = 10;

    function automatic logic [COORD_W-1:0] cell_of(
        input logic [COORD_W-1:0] coord,
        input int                 scale_log2
    );
        return coord >> scale_log2;
    endfunction

    // One extra bit of headroom so the raw sum cannot overflow before the wrap.
    function automatic logic [COORD_W:0] wrap_add(
        input logic [COORD_W:0] a,
        input logic [COORD_W:0] b,
        input int               mod
    );
        logic [COORD_W:0] s;
        logic [COORD_W:0] m;
        m = mod[COORD_W:0];
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

endpackage

// File: rtl/text_scroller_frame_div.sv
// Frame-tick divider. Counts tick pulses while cnt_en is high and emits a
// one-cycle step pulse on the tick that completes each group of N ticks.
// Ports:
//   clk, rst (async, active high)
//   tick    : frame pulse; every high cycle counts
//   cnt_en  : count enable; when low the count holds
//   step    : combinational pulse, high on the N-th counted tick
module frame_div #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic cnt_en,
    output logic step
);

    localparam int                CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             advance;

    always_comb begin
        advance = tick & cnt_en;
        step    = advance & (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (step) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/text_scroller.sv
// Scrolling, blinking one-bit text overlay. Renders a W x H bitmap, scaled by
// 2^SCALE_LOG2 and anchored at (X0_CELL, Y0_CELL), through a VIS_COLS-wide
// window, with frame-rate horizontal scroll and optional blink.
// Ports:
//   clk, rst (async, active high)
//   x, y          : current pixel coordinates from the timing generator
//   frame_tick    : one pulse per frame; all animation state steps on it
//   en            : output enable (animation keeps running when low)
//   scroll_en     : scroll enable; scroll_dir 0 = left (+1), 1 = right (-1)
//   blink_en      : gate the output with the blink phase
//   overlay_active: registered pixel-on flag, one clock after x/y
//   scroll_pos    : current scroll offset into the bitmap columns
module text_scroller
    import text_overlay_pkg::*;
#(
    parameter int             W             = 60,
    parameter int             H             = 10,
    parameter logic [W*H-1:0] BITMAP        = '0,
    parameter int             VIS_COLS      = 60,
    parameter int             X0_CELL       = 11,
    parameter int             Y0_CELL       = 38,
    parameter int             SCALE_LOG2    = 3,
    parameter int             SCROLL_FRAMES = 4,
    parameter int             BLINK_FRAMES  = 30,
    localparam int            POS_W         = (W > 1) ? $clog2(W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    input  logic               en,
    input  logic               scroll_en,
    input  logic               scroll_dir,
    input  logic               blink_en,
    output logic               overlay_active,
    output logic [POS_W-1:0]   scroll_pos
);

    localparam int CW1   = COORD_W + 1;
    localparam int IDX_W = (W * H > 1) ? $clog2(W * H) : 1;
    // Number of conditional subtracts that bring (window col + offset) below W.
    // The largest possible sum is VIS_COLS-1 + W-1.
    localparam int NSUB_RAW = (VIS_COLS + W - 2) / W;
    localparam int NSUB     = (NSUB_RAW > 1) ? NSUB_RAW : 1;

    localparam logic [CW1-1:0]   W_V      = CW1'(W);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(W - 1);

    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    int                 col_i;
    int                 row_i;
    int                 bit_int;
    logic               in_win;
    logic [CW1-1:0]     col_rel;
    logic [CW1-1:0]     col_stage [NSUB];
    logic [IDX_W-1:0]   bit_idx;
    logic               pixel;

    logic               scroll_step;
    logic               blink_toggle;

    logic [POS_W-1:0]   scroll_pos_q;
    logic [POS_W-1:0]   scroll_pos_d;
    logic               blink_phase_q;
    logic               blink_phase_d;
    logic               active_q;
    logic               active_d;

    // Window test in signed integer arithmetic so coordinates left of or
    // above the window can never alias into it.
    always_comb begin
        cx      = cell_of(x, SCALE_LOG2);
        cy      = cell_of(y, SCALE_LOG2);
        col_i   = int'(cx) - X0_CELL;
        row_i   = int'(cy) - Y0_CELL;
        in_win  = (col_i >= 0) && (col_i < VIS_COLS) && (row_i >= 0) && (row_i < H);
        col_rel = CW1'(col_i);
    end

    assign col_stage[0] = wrap_add(col_rel, CW1'(scroll_pos_q), W);

    // Extra subtract stages only exist when the window is wider than the
    // bitmap, in which case the pattern repeats across the window.
    generate
        for (genvar gi = 1; gi < NSUB; gi++) begin : g_wrap
            assign col_stage[gi] = (col_stage[gi-1] >= W_V) ? (col_stage[gi-1] - W_V)
                                                             : col_stage[gi-1];
        end
    endgenerate

    always_comb begin
        bit_int = 0;
        if (in_win) begin
            bit_int = row_i * W + int'(col_stage[NSUB-1]);
        end
        bit_idx = IDX_W'(bit_int);
        pixel   = in_win & BITMAP[bit_idx];
    end

    frame_div #(
        .N (SCROLL_FRAMES)
    ) u_scroll_div (
        .clk    (clk),
        .rst    (rst),
        .tick   (frame_tick),
        .cnt_en (scroll_en),
        .step   (scroll_step)
    );

    frame_div #(
        .N (BLINK_FRAMES)
    ) u_blink_div (
        .clk    (clk),
        .rst    (rst),
        .tick   (frame_tick),
        .cnt_en (1'b1),
        .step   (blink_toggle)
    );

    always_comb begin
        scroll_pos_d = scroll_pos_q;
        if (scroll_step) begin
            if (!scroll_dir) begin
                scroll_pos_d = (scroll_pos_q == LAST_POS) ? '0 : scroll_pos_q + 1'b1;
            end else begin
                scroll_pos_d = (scroll_pos_q == '0) ? LAST_POS : scroll_pos_q - 1'b1;
            end
        end
        blink_phase_d = blink_phase_q ^ blink_toggle;
        active_d      = en & pixel & ~(blink_en & blink_phase_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll_pos_q  <= '0;
            blink_phase_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            scroll_pos_q  <= scroll_pos_d;
            blink_phase_q <= blink_phase_d;
            active_q      <= active_d;
        end
    end

    assign overlay_active = active_q;
    assign scroll_pos     = scroll_pos_q;

endmodule
